// File: rtl/gpio_bank_pkg.sv
// -----------------------------------------------------------------------------
// gpio_bank_pkg
//   Shared constants and helpers for the gpio_bank block.
//   - Register offsets inside one port window (PORT_STRIDE words per port).
//   - Bus width and a small address-window helper used by the top-level decode.
// -----------------------------------------------------------------------------
package gpio_bank_pkg;

  localparam int BUS_W       = 32;
  localparam int PORT_STRIDE = 8;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t OFS_OUT     = 3'd0;
  localparam reg_idx_t OFS_DIR     = 3'd1;
  localparam reg_idx_t OFS_IN      = 3'd2;
  localparam reg_idx_t OFS_SET     = 3'd3;
  localparam reg_idx_t OFS_CLR     = 3'd4;
  localparam reg_idx_t OFS_RISE_EN = 3'd5;
  localparam reg_idx_t OFS_FALL_EN = 3'd6;
  localparam reg_idx_t OFS_STATUS  = 3'd7;

  // True when addr lies in [base, base+span). The explicit lower-bound test
  // keeps addresses below base from wrapping into the window.
  function automatic logic in_window(input logic [BUS_W-1:0] addr,
                                     input logic [BUS_W-1:0] base,
                                     input logic [BUS_W-1:0] span);
    logic [BUS_W-1:0] off;
    off = addr - base;
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/gpio_bank_port.sv
// -----------------------------------------------------------------------------
// gpio_bank_port
//   One GPIO port: OUT/DIR registers with atomic SET/CLR, a SYNC_STAGES-deep
//   input synchroniser, rise/fall edge capture into a sticky W1C STATUS
//   register, and the per-port read mux.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   wr_en           decoded write strobe for this port (already address-hit)
//   wr_idx          register index of the write (0..7)
//   wr_data         bus write data; bits above WIDTH are ignored
//   rd_idx          register index of the current read address
//   pin_in          raw pad inputs (asynchronous to clk)
//   out_q, dir_q    pad output value / direction (1 = drive)
//   rd_data         zero-extended read value for rd_idx
//   status_any      OR of STATUS bits (combinational, registered by the top)
// -----------------------------------------------------------------------------
module gpio_bank_port
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  reg_idx_t         wr_idx,
  input  logic [BUS_W-1:0] wr_data,
  input  reg_idx_t         rd_idx,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] dir_q,
  output logic [BUS_W-1:0] rd_data,
  output logic             status_any
);

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] w1c_mask;

  logic we_out, we_dir, we_set, we_clr, we_rise, we_fall, we_status;

  assign wdata = wr_data[WIDTH-1:0];

  // Write-enable decode. IN is read-only, so no strobe exists for it.
  always_comb begin
    we_out    = wr_en && (wr_idx == OFS_OUT);
    we_dir    = wr_en && (wr_idx == OFS_DIR);
    we_set    = wr_en && (wr_idx == OFS_SET);
    we_clr    = wr_en && (wr_idx == OFS_CLR);
    we_rise   = wr_en && (wr_idx == OFS_RISE_EN);
    we_fall   = wr_en && (wr_idx == OFS_FALL_EN);
    we_status = wr_en && (wr_idx == OFS_STATUS);
  end

  // OUT: plain write or atomic read-modify-write. A single write per cycle
  // means at most one of these strobes is active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (we_out) begin
      out_q <= wdata;
    end else if (we_set) begin
      out_q <= out_q | wdata;
    end else if (we_clr) begin
      out_q <= out_q & ~wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else begin
      if (we_dir)  dir_q     <= wdata;
      if (we_rise) rise_en_q <= wdata;
      if (we_fall) fall_en_q <= wdata;
    end
  end

  // Synchroniser chain: stage 0 samples the pad, the last stage is IN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign in_val = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= in_val;
    end
  end

  assign rise = in_val & ~prev_q;
  assign fall = ~in_val & prev_q;

  // Clear is applied before the new-edge OR, so an edge arriving in the same
  // cycle as its W1C survives (set wins).
  always_comb begin
    w1c_mask = we_status ? wdata : '0;
    status_d = (status_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_any = |status_q;

  // Read mux; upper bus bits stay 0 for WIDTH < 32, SET/CLR read as 0.
  always_comb begin
    rd_data = '0;
    case (rd_idx)
      OFS_OUT:     rd_data[WIDTH-1:0] = out_q;
      OFS_DIR:     rd_data[WIDTH-1:0] = dir_q;
      OFS_IN:      rd_data[WIDTH-1:0] = in_val;
      OFS_RISE_EN: rd_data[WIDTH-1:0] = rise_en_q;
      OFS_FALL_EN: rd_data[WIDTH-1:0] = fall_en_q;
      OFS_STATUS:  rd_data[WIDTH-1:0] = status_q;
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
//   N_PORTS x WIDTH GPIO controller on the peripheral bus. Port p, register r
//   lives at word address BASE + 8*p + r.
//
// Bus protocol: sys_w is a single-cycle write qualifier, one write per cycle
// accepted at the rising clk edge whenever the address hits; there is no
// back-pressure. sys_r is a combinational read qualifier: while sys_r is high
// and sys_r_addr hits the block, sys_r_line carries the addressed register in
// the same cycle, otherwise this block leaves sys_r_line at high-Z.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   sys_w_addr, sys_w_line   write address / data, qualified by sys_w
//   sys_r_addr               read address, qualified by sys_r
//   sys_r_line               shared tri-state read data
//   pin_in                   pad inputs, port p at [p*WIDTH +: WIDTH]
//   pin_out, pin_dir         pad outputs / directions (1 = drive)
//   irq_port                 registered per-port pending interrupt
//   irq                      registered OR of all ports
// -----------------------------------------------------------------------------
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          N_PORTS     = 4,
  parameter logic [31:0] BASE        = 32'h20,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_W-1:0]           sys_w_addr,
  input  logic [BUS_W-1:0]           sys_r_addr,
  input  logic [BUS_W-1:0]           sys_w_line,
  output logic [BUS_W-1:0]           sys_r_line,
  input  logic                       sys_w,
  input  logic                       sys_r,
  input  logic [N_PORTS*WIDTH-1:0]   pin_in,
  output logic [N_PORTS*WIDTH-1:0]   pin_out,
  output logic [N_PORTS*WIDTH-1:0]   pin_dir,
  output logic [N_PORTS-1:0]         irq_port,
  output logic                       irq
);

  localparam logic [BUS_W-1:0] SPAN = BUS_W'(PORT_STRIDE * N_PORTS);

  logic [BUS_W-1:0] w_off;
  logic [BUS_W-1:0] r_off;
  logic             w_hit;
  logic             r_hit;
  reg_idx_t         w_idx;
  reg_idx_t         r_idx;

  logic [N_PORTS-1:0] port_wr_en;
  logic [N_PORTS-1:0] status_any;
  logic [BUS_W-1:0]   port_rd [N_PORTS];
  logic [BUS_W-1:0]   rd_sel;

  // Address decode: offset within the block, port = offset/8, reg = offset%8.
  assign w_off = sys_w_addr - BASE;
  assign r_off = sys_r_addr - BASE;
  assign w_hit = sys_w && in_window(sys_w_addr, BASE, SPAN);
  assign r_hit = sys_r && in_window(sys_r_addr, BASE, SPAN);
  assign w_idx = w_off[2:0];
  assign r_idx = r_off[2:0];

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign port_wr_en[p] = w_hit && (w_off[BUS_W-1:3] == (BUS_W-3)'(p));

    gpio_bank_port #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (port_wr_en[p]),
      .wr_idx     (w_idx),
      .wr_data    (sys_w_line),
      .rd_idx     (r_idx),
      .pin_in     (pin_in[p*WIDTH +: WIDTH]),
      .out_q      (pin_out[p*WIDTH +: WIDTH]),
      .dir_q      (pin_dir[p*WIDTH +: WIDTH]),
      .rd_data    (port_rd[p]),
      .status_any (status_any[p])
    );
  end

  // Port select for the read path; only meaningful when r_hit is set.
  always_comb begin
    rd_sel = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (r_off[BUS_W-1:3] == (BUS_W-3)'(p)) rd_sel = port_rd[p];
    end
  end

  assign sys_r_line = r_hit ? rd_sel : {BUS_W{1'bz}};

  // irq is built from the same next-values as irq_port so both assert on the
  // same edge rather than irq trailing by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_port <= '0;
      irq      <= 1'b0;
    end else begin
      irq_port <= status_any;
      irq      <= |status_any;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;

  localparam int          W    = 32;
  localparam int          NP   = 4;
  localparam logic [31:0] BASE = 32'h20;
  localparam logic [31:0] B8   = 32'h100;

  logic          clk;
  logic          rst;
  logic [31:0]   sys_w_addr;
  logic [31:0]   sys_r_addr;
  logic [31:0]   sys_w_line;
  logic          sys_w;
  logic          sys_r;
  wire  [31:0]   sys_r_line;
  wire  [31:0]   sys_r_line8;
  logic [NP*W-1:0] pin_in;
  logic [NP*W-1:0] pin_out;
  logic [NP*W-1:0] pin_dir;
  logic [NP-1:0]   irq_port;
  logic            irq;
  logic [15:0]     pin_in8;
  logic [15:0]     pin_out8;
  logic [15:0]     pin_dir8;
  logic [1:0]      irq_port8;
  logic            irq8;

  int total;
  int bad;

  gpio_bank #(.WIDTH(W), .N_PORTS(NP), .BASE(BASE), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sys_w_addr (sys_w_addr),
    .sys_r_addr (sys_r_addr),
    .sys_w_line (sys_w_line),
    .sys_r_line (sys_r_line),
    .sys_w      (sys_w),
    .sys_r      (sys_r),
    .pin_in     (pin_in),
    .pin_out    (pin_out),
    .pin_dir    (pin_dir),
    .irq_port   (irq_port),
    .irq        (irq)
  );

  // Narrow instance in its own address window for the WIDTH truncation case.
  gpio_bank #(.WIDTH(8), .N_PORTS(2), .BASE(B8), .SYNC_STAGES(2)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .sys_w_addr (sys_w_addr),
    .sys_r_addr (sys_r_addr),
    .sys_w_line (sys_w_line),
    .sys_r_line (sys_r_line8),
    .sys_w      (sys_w),
    .sys_r      (sys_r),
    .pin_in     (pin_in8),
    .pin_out    (pin_out8),
    .pin_dir    (pin_dir8),
    .irq_port   (irq_port8),
    .irq        (irq8)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- drivers ----------------
  // Write: drive on a falling edge, commits on the next rising edge, returns
  // on the falling edge just after the commit.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    sys_w_addr = addr;
    sys_w_line = data;
    sys_w      = 1'b1;
    @(negedge clk);
    sys_w      = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    sys_r_addr = addr;
    sys_r      = 1'b1;
    #1;
    data = sys_r_line;
    sys_r      = 1'b0;
  endtask

  task automatic bus_read8(input logic [31:0] addr, output logic [31:0] data);
    sys_r_addr = addr;
    sys_r      = 1'b1;
    #1;
    data = sys_r_line8;
    sys_r      = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b0;
    pin_in = '1;
    wait_neg(5);
    rst = 1'b1;
    if (pin_out !== '0) begin bad++; $display("FAIL reset_pin_out: got %h expected 0", pin_out); end
    total++;
    if (pin_dir !== '0) begin bad++; $display("FAIL reset_pin_dir: got %h expected 0", pin_dir); end
    total++;
    if (irq !== 1'b0 || irq_port !== '0) begin
      bad++; $display("FAIL reset_irq: got irq=%b irq_port=%b expected 0/0", irq, irq_port);
    end
    total++;
    wait_neg(1);
    bus_read(BASE + 2, d);
    if (d !== 32'h0) begin bad++; $display("FAIL reset_in_fill1: got %h expected 00000000", d); end
    total++;
    wait_neg(1);
    bus_read(BASE + 2, d);
    if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_in_fill2: got %h expected ffffffff", d); end
    total++;
    wait_neg(3);
    bus_read(BASE + 7, d);
    if (d !== 32'h0) begin bad++; $display("FAIL reset_status: got %h expected 0", d); end
    total++;
  endtask

  task automatic test_atomic;
    logic [31:0] d;
    bus_write(BASE + 8,  32'h0000_00F0);
    bus_write(BASE + 11, 32'h0000_000F);
    bus_write(BASE + 12, 32'h0000_0030);
    bus_read(BASE + 8, d);
    if (d !== 32'h0000_00CF) begin bad++; $display("FAIL atomic_read: got %h expected 000000cf", d); end
    total++;
    if (pin_out[63:32] !== 32'h0000_00CF) begin
      bad++; $display("FAIL atomic_pin_out: got %h expected 000000cf", pin_out[63:32]);
    end
    total++;
    if (pin_out[31:0] !== 32'h0 || pin_out[127:64] !== 64'h0) begin
      bad++; $display("FAIL atomic_others: got %h expected only port1 set", pin_out);
    end
    total++;
    bus_read(BASE + 11, d);
    if (d !== 32'h0) begin bad++; $display("FAIL set_reads_zero: got %h expected 0", d); end
    total++;
    bus_write(BASE + 9, 32'h0000_5A5A);
    bus_read(BASE + 9, d);
    if (d !== 32'h0000_5A5A || pin_dir[63:32] !== 32'h0000_5A5A) begin
      bad++; $display("FAIL dir_rw: got %h pin_dir=%h expected 00005a5a", d, pin_dir[63:32]);
    end
    total++;
  endtask

  task automatic test_edge_irq;
    logic [31:0] d;
    pin_in = '0;
    wait_neg(4);
    bus_write(BASE + 21, 32'h1);
    pin_in[64] = 1'b1;            // sampled at edge k
    wait_neg(2);                  // after k+1
    bus_read(BASE + 23, d);
    if (d !== 32'h0) begin bad++; $display("FAIL edge_early: got %h expected 0", d); end
    total++;
    wait_neg(1);                  // after k+2
    bus_read(BASE + 23, d);
    if (d !== 32'h1 || irq_port[2] !== 1'b0) begin
      bad++; $display("FAIL edge_status: got %h irq_port2=%b expected 1/0", d, irq_port[2]);
    end
    total++;
    wait_neg(1);                  // after k+3
    if (irq_port !== 4'b0100 || irq !== 1'b1) begin
      bad++; $display("FAIL edge_irq: got irq_port=%b irq=%b expected 0100/1", irq_port, irq);
    end
    total++;
    pin_in[64] = 1'b0;
    wait_neg(4);
    bus_read(BASE + 23, d);
    if (d !== 32'h1) begin bad++; $display("FAIL fall_ignored: got %h expected 1", d); end
    total++;
    bus_write(BASE + 23, 32'h1);
    wait_neg(2);
    if (irq !== 1'b0) begin bad++; $display("FAIL edge_cleared: got irq=%b expected 0", irq); end
    total++;
  endtask

  task automatic test_w1c_race;
    logic [31:0] d;
    bus_write(BASE + 6, 32'h8);
    pin_in[3] = 1'b1;
    wait_neg(4);
    pin_in[3] = 1'b0;
    wait_neg(4);
    bus_read(BASE + 7, d);
    if (d !== 32'h8) begin bad++; $display("FAIL fall_set: got %h expected 8", d); end
    total++;
    pin_in[3] = 1'b1;
    wait_neg(4);
    pin_in[3] = 1'b0;             // edge k samples the fall
    wait_neg(2);                  // after k+1
    sys_w_addr = BASE + 7;
    sys_w_line = 32'h8;
    sys_w      = 1'b1;            // commits at k+2, same edge the fall sets
    wait_neg(1);
    sys_w      = 1'b0;
    bus_read(BASE + 7, d);
    if (d !== 32'h8) begin bad++; $display("FAIL w1c_race: got %h expected 8", d); end
    total++;
    bus_write(BASE + 7, 32'h8);
    bus_read(BASE + 7, d);
    if (d !== 32'h0 || irq !== 1'b1) begin
      bad++; $display("FAIL w1c_clear: got %h irq=%b expected 0/1", d, irq);
    end
    total++;
    wait_neg(1);
    if (irq !== 1'b0 || irq_port !== '0) begin
      bad++; $display("FAIL w1c_irq_drop: got irq=%b irq_port=%b expected 0", irq, irq_port);
    end
    total++;
  endtask

  task automatic test_decode;
    logic [31:0] d;
    logic [NP*W-1:0] out_before;
    bus_write(BASE + 0, 32'h0000_1234);
    bus_read(BASE - 1, d);
    // Undriven bus resolves to z in a 4-state simulator and to 0 in 2-state.
    if (d !== 32'hz && d !== 32'h0) begin bad++; $display("FAIL decode_low: got %h expected z", d); end
    total++;
    bus_read(BASE + 32, d);
    if (d !== 32'hz && d !== 32'h0) begin bad++; $display("FAIL decode_high: got %h expected z", d); end
    total++;
    bus_read(BASE + 0, d);
    if (d !== 32'h0000_1234) begin bad++; $display("FAIL decode_hit: got %h expected 00001234", d); end
    total++;
    out_before = pin_out;
    bus_write(BASE + 2, 32'hDEAD_BEEF);
    bus_write(BASE + 32, 32'hFFFF_FFFF);
    bus_write(BASE - 1, 32'hFFFF_FFFF);
    bus_read(BASE + 2, d);
    if (d !== pin_in[31:0]) begin bad++; $display("FAIL in_readonly: got %h expected %h", d, pin_in[31:0]); end
    total++;
    if (pin_out !== {64'h0, 32'h0000_00CF, 32'h0000_1234}) begin
      bad++; $display("FAIL stray_write: got %h expected %h", pin_out, out_before);
    end
    total++;
    bus_write(B8 + 0, 32'h0000_FFFF);
    bus_read8(B8 + 0, d);
    if (d !== 32'h0000_00FF) begin bad++; $display("FAIL width8_read: got %h expected 000000ff", d); end
    total++;
    if (pin_out8 !== 16'h00FF) begin bad++; $display("FAIL width8_pin: got %h expected 00ff", pin_out8); end
    total++;
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    int guard;
    bus_write(BASE + 0, 32'h0000_00A5);
    bus_write(BASE + 1, 32'h0000_00FF);
    bus_write(BASE + 5, 32'h1);
    pin_in[0] = 1'b1;
    guard = 0;
    while (irq !== 1'b1 && guard < 20) begin
      wait_neg(1);
      guard++;
    end
    if (irq !== 1'b1) begin bad++; $display("FAIL async_pre_irq: got %b expected 1", irq); end
    total++;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    if (pin_out !== '0 || pin_dir !== '0) begin
      bad++; $display("FAIL async_pins: got out=%h dir=%h expected 0", pin_out, pin_dir);
    end
    total++;
    if (irq !== 1'b0 || irq_port !== '0 || pin_out8 !== '0) begin
      bad++; $display("FAIL async_irq: got irq=%b irq_port=%b out8=%h expected 0", irq, irq_port, pin_out8);
    end
    total++;
    @(negedge clk);
    rst = 1'b1;
    pin_in = '0;
    bus_read(BASE + 7, d);
    if (d !== 32'h0) begin bad++; $display("FAIL async_status: got %h expected 0", d); end
    total++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    sys_w = 1'b0;
    sys_r = 1'b0;
    sys_w_addr = '0;
    sys_r_addr = '0;
    sys_w_line = '0;
    pin_in = '0;
    pin_in8 = '0;
    test_reset();
    test_atomic();
    test_edge_irq();
    test_w1c_race();
    test_decode();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
